// File: rtl/core_id_reg_wr_arbiter.sv
// ID-stage register-file write arbiter: LSU priority with EX anti-starvation.
// Optional post-reset x1..x31 clear enabled by REG_INIT_CLEAR_EN.
module core_id_reg_wr_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  output logic              init_busy
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]     starve_q, starve_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              in_init;
  logic              ex_force;

`ifdef REG_INIT_CLEAR_EN
  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;

  assign in_init = (state_q == S_INIT);

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (in_init) begin
      init_addr_d = init_addr_q + ADDR_W'(1);
      if (init_addr_q == ADDR_W'(31)) begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_addr_q <= ADDR_W'(1);
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end
`else
  assign in_init = 1'b0;
`endif

  assign init_busy = in_init;

  // Grant: LSU wins unless EX has been refused STARVE_MAX cycles in a row.
  always_comb begin
    ex_force  = (starve_q == CW'(STARVE_MAX));
    lsu_ready = 1'b0;
    ex_ready  = 1'b0;
    if (!in_init) begin
      lsu_ready = lsu_valid && !(ex_valid && ex_force);
      ex_ready  = ex_valid && !lsu_ready;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (ex_ready || !ex_valid) begin
      starve_d = '0;
    end else if (!ex_force) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // x0 transfers complete the handshake but leave the port idle.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef REG_INIT_CLEAR_EN
    if (in_init) begin
      wr_en_d   = 1'b1;
      wr_addr_d = init_addr_q;
      wr_data_d = '0;
    end else
`endif
    if (lsu_ready) begin
      if (lsu_addr != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = lsu_addr;
        wr_data_d = lsu_data;
      end
    end else if (ex_ready) begin
      if (ex_addr != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ex_addr;
        wr_data_d = ex_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign rf_write_en   = wr_en_q;
  assign rf_write_addr = wr_addr_q;
  assign rf_write_data = wr_data_q;

endmodule

// File: tb/tb_core_id_reg_wr_arbiter.sv
// Randomized bench for core_id_reg_wr_arbiter against a cycle-level model.
// Honours REG_INIT_CLEAR_EN the same way the design does.
module tb_core_id_reg_wr_arbiter;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_addr = '0;
  logic [31:0] ex_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_addr = '0;
  logic [31:0] lsu_data = '0;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_write_en;
  logic        init_busy;

  core_id_reg_wr_arbiter #(
    .DATA_W(32),
    .ADDR_W(5),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_addr(ex_addr),
    .ex_data(ex_data),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_addr(lsu_addr),
    .lsu_data(lsu_data),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .rf_write_en(rf_write_en),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: init_next counts the clear sequence, refused counts EX refusals.
  int          init_next;
  int          refused;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] shadow [32];

`ifdef REG_INIT_CLEAR_EN
  localparam int INIT_START = 1;
`else
  localparam int INIT_START = 32;
`endif

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    init_next = INIT_START;
    refused   = 0;
    m_en      = 1'b0;
    m_addr    = '0;
    m_data    = '0;
  endtask

  // Called at posedge+1; returns with time at the following posedge+1.
  task automatic step(input logic ev, input logic [4:0] ea,
                      input logic [31:0] ed, input logic lv,
                      input logic [4:0] la, input logic [31:0] ld,
                      output logic got_ex, output logic got_lsu);
    logic m_ex, m_lsu;
    ex_valid  = ev;
    ex_addr   = ea;
    ex_data   = ed;
    lsu_valid = lv;
    lsu_addr  = la;
    lsu_data  = ld;
    #2;
    if (init_next <= 31) begin
      m_ex  = 1'b0;
      m_lsu = 1'b0;
    end else begin
      m_lsu = lv && !(ev && refused >= SMAX);
      m_ex  = ev && !m_lsu;
    end
    chk("ex_ready", {63'd0, ex_ready}, {63'd0, m_ex});
    chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, m_lsu});
    got_ex  = ex_ready;
    got_lsu = lsu_ready;
    if (m_ex || !ev) refused = 0;
    else if (refused < SMAX) refused++;
    if (init_next <= 31) begin
      m_en   = 1'b1;
      m_addr = 5'(init_next);
      m_data = '0;
      init_next++;
    end else if (m_lsu && la != 0) begin
      m_en = 1'b1; m_addr = la; m_data = ld;
    end else if (m_ex && !m_lsu && ea != 0) begin
      m_en = 1'b1; m_addr = ea; m_data = ed;
    end else begin
      m_en = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rf_write_en", {63'd0, rf_write_en}, {63'd0, m_en});
    chk("rf_write_addr", {59'd0, rf_write_addr}, {59'd0, m_addr});
    chk("rf_write_data", {32'd0, rf_write_data}, {32'd0, m_data});
    chk("init_busy", {63'd0, init_busy}, {63'd0, logic'(init_next <= 31)});
    if (rf_write_en) shadow[rf_write_addr] = rf_write_data;
  endtask

  // Asynchronous reset: outputs must clear without waiting for an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_en", {63'd0, rf_write_en}, 64'd0);
    chk("rst_addr", {59'd0, rf_write_addr}, 64'd0);
    chk("rst_data", {32'd0, rf_write_data}, 64'd0);
    chk("rst_busy", {63'd0, init_busy}, {63'd0, logic'(init_next <= 31)});
    ex_valid  = 1'b0;
    lsu_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic ge, gl;
  logic pat [5];

  initial begin
    foreach (shadow[i]) shadow[i] = '0;
    @(posedge clk);
    #1;
    do_reset();

`ifdef REG_INIT_CLEAR_EN
    // Clear sequence with EX waiting, then first EX grant.
    for (int i = 0; i < 31; i++) step(1, 5'd3, 32'h1234, 0, 0, 0, ge, gl);
    step(1, 5'd3, 32'h1234, 0, 0, 0, ge, gl);
    chk("t1_grant", {63'd0, ge}, 64'd1);
    chk("t1_busy", {63'd0, init_busy}, 64'd0);
`endif

    step(0, 0, 0, 0, 0, 0, ge, gl);
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, ge, gl);
    chk("t2_ready", {63'd0, ge}, 64'd1);
    chk("t2_data", {32'd0, rf_write_data}, 64'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, ge, gl);

    for (int i = 0; i < 5; i++) begin
      step(1, 5'd2, 32'hA0 + 32'(i), 1, 5'd3, 32'hB0 + 32'(i), ge, gl);
      pat[i] = ge;
    end
    chk("t3_pattern", {59'd0, pat[0], pat[1], pat[2], pat[3], pat[4]},
        64'b00010);
    step(0, 0, 0, 0, 0, 0, ge, gl);

    step(1, 5'd7, 32'd1, 1, 5'd7, 32'd2, ge, gl);
    chk("t4_lsu_first", {63'd0, gl}, 64'd1);
    step(1, 5'd7, 32'd1, 0, 0, 0, ge, gl);
    chk("t4_ex_second", {63'd0, ge}, 64'd1);
    step(0, 0, 0, 0, 0, 0, ge, gl);
    chk("t4_final_x7", {32'd0, shadow[7]}, 64'd1);

    step(1, 5'd0, 32'hFFFF, 0, 0, 0, ge, gl);
    chk("t5_ready", {63'd0, ge}, 64'd1);

    // Reset while a write is on the port and a new transfer is offered.
    step(1, 5'd9, 32'h55, 0, 0, 0, ge, gl);
    ex_valid = 1'b1;
    do_reset();
`ifdef REG_INIT_CLEAR_EN
    while (init_next < 10) step(0, 0, 0, 0, 0, 0, ge, gl);
    do_reset();
    step(0, 0, 0, 0, 0, 0, ge, gl);
    chk("t6_restart", {59'd0, rf_write_addr}, 64'd1);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(logic'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom, logic'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 31)), $urandom, ge, gl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
